// File: rtl/lwdo_wb_stream_regs.sv
// lwdo_wb_stream_regs
// Pipelined Wishbone register slave for LWDO. It exposes the MAGIC, CTRL and
// STATUS registers and one pop-on-read DATA register per stream channel.
// Channel c's FIFO head is popped by a read of word 4+c, but only when that
// channel is enabled and holds data.
`timescale 1ns/1ps

module lwdo_wb_stream_regs #(
    parameter int          ADDRESS_WIDTH     = 10,
    parameter int          NCH               = 2,
    parameter logic [31:0] MAGIC             = 32'h4C57444F,
    parameter logic [31:0] DEFAULT_READ_DATA = 32'hDEADBEEF,
    parameter logic [31:0] EMPTY_DATA        = 32'h00000000,
    parameter int          SOFT_RST_CYCLES   = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    input  logic                     i_wb_we,
    input  logic [ADDRESS_WIDTH-1:0] i_wb_adr,
    input  logic [31:0]              i_wb_dat,
    input  logic [3:0]               i_wb_sel,
    output logic [31:0]              o_wb_dat,
    input  logic [32*NCH-1:0]        i_str_data,
    input  logic [NCH-1:0]           i_str_valid,
    output logic [NCH-1:0]           o_str_rd,
    output logic [NCH-1:0]           o_ch_en,
    output logic                     o_soft_rst
);

    localparam int WW = ADDRESS_WIDTH - 2;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int SW = $clog2(SOFT_RST_CYCLES + 1);

    logic              w_accept;
    logic              w_rdAccept;
    logic              w_wrAccept;
    logic [WW-1:0]     w_word;
    logic              w_isMagic;
    logic              w_isCtrl;
    logic              w_isStatus;
    logic              w_isData;
    logic [CW-1:0]     w_ch;
    logic [31:0]       w_byteMask;
    logic [31:0]       w_wrBits;
    logic [31:0]       w_ctrlRd;
    logic [31:0]       w_statusRd;
    logic [31:0]       w_head;
    logic [31:0]       w_rdData;
    logic [NCH-1:0]    w_pop;
    logic [NCH-1:0]    w_uflowHit;
    logic [NCH-1:0]    w_uflowClr;
    logic [NCH-1:0]    w_enNext;
    logic              w_unused;

    logic              r_ack;
    logic [31:0]       r_wbDat;
    logic [NCH-1:0]    r_chEn;
    logic [NCH-1:0]    r_uflow;
    logic [NCH-1:0]    r_uflowPend;
    logic [SW-1:0]     r_softCnt;

    assign w_accept   = i_wb_cyc & i_wb_stb;
    assign w_rdAccept = w_accept & ~i_wb_we;
    assign w_wrAccept = w_accept & i_wb_we;

    assign w_word     = i_wb_adr[ADDRESS_WIDTH-1:2];
    assign w_isMagic  = (w_word == WW'(0));
    assign w_isCtrl   = (w_word == WW'(1));
    assign w_isStatus = (w_word == WW'(2));
    assign w_isData   = (w_word >= WW'(4)) && (w_word < WW'(4 + NCH));
    assign w_ch       = CW'(w_word - WW'(4));

    assign w_byteMask = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
    assign w_wrBits   = i_wb_dat & w_byteMask;
    assign w_enNext   = (r_chEn & ~w_byteMask[16 +: NCH]) | w_wrBits[16 +: NCH];
    assign w_uflowClr = (w_wrAccept && w_isStatus) ? w_wrBits[16 +: NCH] : '0;

    assign w_ctrlRd   = (32'(r_chEn) << 16) | {31'd0, o_soft_rst};
    assign w_statusRd = (32'(r_uflow) << 16) | 32'(i_str_valid & r_chEn);

    assign w_unused   = &{1'b0, i_wb_adr[1:0], w_wrBits};

    // Select the addressed channel: head word and pop when it has data, underflow when enabled but empty
    always_comb begin
        w_pop      = '0;
        w_uflowHit = '0;
        w_head     = EMPTY_DATA;
        for (int c = 0; c < NCH; c++) begin
            if (w_isData && (w_ch == CW'(c))) begin
                if (r_chEn[c] && i_str_valid[c]) begin
                    w_head   = i_str_data[32*c +: 32];
                    w_pop[c] = 1'b1;
                end else if (r_chEn[c]) begin
                    w_uflowHit[c] = 1'b1;
                end
            end
        end
    end

    // Read data multiplexer over the word map
    always_comb begin
        w_rdData = DEFAULT_READ_DATA;
        if (w_isMagic) begin
            w_rdData = MAGIC;
        end else if (w_isCtrl) begin
            w_rdData = w_ctrlRd;
        end else if (w_isStatus) begin
            w_rdData = w_statusRd;
        end else if (w_isData) begin
            w_rdData = w_head;
        end
    end

    // Bus ack and registered read data, one cycle after accept
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack   <= 1'b0;
            r_wbDat <= 32'd0;
        end else begin
            r_ack <= w_accept;
            if (w_rdAccept) begin
                r_wbDat <= w_rdData;
            end
        end
    end

    // Channel enables, byte-lane masked CTRL writes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_chEn <= '0;
        end else if (w_wrAccept && w_isCtrl) begin
            r_chEn <= w_enNext;
        end
    end

    // Soft-reset timer: writing a 1 (re)loads it, otherwise it counts down to zero
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_softCnt <= '0;
        end else if (w_wrAccept && w_isCtrl && w_wrBits[0]) begin
            r_softCnt <= SW'(SOFT_RST_CYCLES);
        end else if (r_softCnt != '0) begin
            r_softCnt <= r_softCnt - SW'(1);
        end
    end

    // Sticky underflow flags; the set lands one cycle after the read so it can meet a W1C and win
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_uflowPend <= '0;
            r_uflow     <= '0;
        end else begin
            r_uflowPend <= w_rdAccept ? w_uflowHit : '0;
            r_uflow     <= (r_uflow & ~w_uflowClr) | r_uflowPend;
        end
    end

    assign o_wb_stall = 1'b0;
    assign o_wb_ack   = r_ack & i_wb_cyc;
    assign o_wb_dat   = r_wbDat;
    assign o_str_rd   = w_pop & {NCH{w_rdAccept & ~i_rst}};
    assign o_ch_en    = r_chEn;
    assign o_soft_rst = (r_softCnt != '0);

endmodule
